echo_delay_scheduler: RTL
=========================

// Module: echo_delay_scheduler
// PURPOSE
// - Sequences one 16-bit echo per audio sample over an external single-port synchronous RAM used as the circular delay line.
// - Per accepted sample: reads the delayed tap, mixes out = in + (tap >>> ATTEN), writes the mixed value back as feedback, presents the result.
// - Sits between codec sample strobe and DAC path; replaces the fixed shift-register delay with runtime-configurable length and attenuation.
// PARAMETERS
// - ADDR_W   10   RAM address width; delay depth = 2**ADDR_W samples
// - DATA_W   16   signed sample width
// PORTS
// - clock          in   1        single system clock, all logic posedge
// - reset_n        in   1        asynchronous, active-low reset
// - sample_valid   in   1        one-cycle strobe: input_sample is valid
// - input_sample   in   DATA_W   signed dry sample
// - cfg_load       in   1        request to load cfg_delay/cfg_atten
// - cfg_delay      in   ADDR_W   delay length in samples (0 treated as 1)
// - cfg_atten      in   4        arithmetic right-shift of delayed tap (0..15)
// - ram_addr       out  ADDR_W   RAM address
// - ram_we         out  1        RAM write enable
// - ram_wdata      out  DATA_W   RAM write data
// - ram_rdata      in   DATA_W   RAM read data, valid 1 cycle after address
// - output_sample  out  DATA_W   signed mixed sample, held until next result
// - output_valid   out  1        one-cycle strobe: output_sample updated
// - overrun        out  1        sticky: sample_valid arrived while busy
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, ptr 0, delay_len 1, atten 8, overrun 0.
// - FSM: IDLE -> READ -> MIX -> WRITE -> IDLE. One sample in flight only.
// - IDLE: on sample_valid latch input_sample, go READ. Else if cfg_load: delay_len <= max(cfg_delay,1), atten <= cfg_atten, ptr <= 0; stay IDLE.
// - sample_valid and cfg_load same cycle in IDLE: sample wins, cfg_load ignored (requester re-asserts).
// - READ: ram_addr = ptr, ram_we = 0. MIX: capture ram_rdata, compute sum with DATA_W+1 bits, tap shifted arithmetically (sign-preserving).
// - WRITE: ram_addr = ptr, ram_we = 1, ram_wdata = result; output_sample <= result, output_valid = 1;
//   ptr <= (ptr == delay_len-1) ? 0 : ptr+1.
// - Latency: output_valid exactly 3 cycles after the accepting sample_valid cycle; max accepted rate 1 sample / 4 cycles.
// - sample_valid in READ/MIX/WRITE: sample dropped, overrun <= 1; cleared only by reset or cfg_load accepted in IDLE.
// - Reset mid-sequence: aborts, no RAM write occurs after reset asserts; RAM contents undefined-but-stale (not cleared).
// - After cfg load delay line holds stale data from previous config; no clear pass.
// - ram_we high only in WRITE; ram_addr = ptr in all other states.
// CONFIGURATION
// - ECHO_SATURATE_EN defined: result clamped to [-2**(DATA_W-1), 2**(DATA_W-1)-1] from the DATA_W+1 sum.
// - Not defined: result = low DATA_W bits of sum (two's-complement wrap).
// STRUCTURE
// - Shared package echo_pkg: state enum {IDLE,READ,MIX,WRITE}, DATA_W/ADDR_W defaults, reset atten constant 8, SAT_MAX/SAT_MIN.
// - One sub-module: echo_mix (combinational: tap shift, widened add, optional saturation); FSM/pointer stay in top.
// TESTING
// - Reset, no samples -> all outputs 0, ram_we never 1, ptr 0.
// - cfg delay=4 atten=1, impulse 1000 then zeros every 8 cycles -> outputs 1000,0,0,0,500,0,0,0,250 ...; output_valid 3 cycles after each strobe.
// - cfg delay=2 atten=0, inputs 30000 repeated -> with ECHO_SATURATE_EN output pins at 32767; without, wraps to -5536 on 2nd echo pass.
// - sample_valid on back-to-back cycles -> 2nd dropped, overrun=1, one output_valid; cfg_load in IDLE clears overrun.
// - sample_valid and cfg_load same IDLE cycle -> sample processed, delay_len unchanged; negative tap -16 atten 2 -> contributes -4.
// - reset_n asserted during WRITE of ptr 3 -> ram_we drops immediately, outputs 0, next sample uses ptr 0.

Source files
------------

// File: rtl/echo_pkg.sv
// -----------------------------------------------------------------------------
// echo_pkg
// Shared definitions for the echo delay scheduler: sequencing states, default
// widths, the attenuation loaded at reset and the saturation limits for the
// default sample width.
// Optional build macro used by the datapath: ECHO_SATURATE_EN.
// -----------------------------------------------------------------------------
package echo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      MIX   = 2'd2,
      WRITE = 2'd3
   } state_t;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 10;

   localparam logic [3:0] ATTEN_RST = 4'd8;

   localparam logic signed [DEF_DATA_W-1:0] SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
   localparam logic signed [DEF_DATA_W-1:0] SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

endpackage : echo_pkg

// File: rtl/echo_mix.sv
// -----------------------------------------------------------------------------
// echo_mix
// Combinational echo mixer: result = dry + (tap >>> atten).
// The shift is arithmetic so negative taps decay towards -1 rather than
// turning into large positive values.
// Build macro: ECHO_SATURATE_EN
//   defined   : sum is formed DATA_W+1 bits wide and clamped to the signed
//               DATA_W range.
//   undefined : result is the low DATA_W bits of the sum (two's-complement
//               wrap).
// Ports
//   dry_i     in   DATA_W   signed dry sample
//   tap_i     in   DATA_W   signed delayed tap read from the delay line
//   atten_i   in   4        right-shift applied to the tap
//   result_o  out  DATA_W   mixed sample
// -----------------------------------------------------------------------------
module echo_mix
   import echo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic signed [DATA_W-1:0] dry_i,
   input  logic signed [DATA_W-1:0] tap_i,
   input  logic        [3:0]        atten_i,
   output logic signed [DATA_W-1:0] result_o
);

   logic signed [DATA_W-1:0] tap_shift;

   assign tap_shift = tap_i >>> atten_i;

`ifdef ECHO_SATURATE_EN
   localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

   logic signed [DATA_W:0] sum;

   assign sum = {dry_i[DATA_W-1], dry_i} + {tap_shift[DATA_W-1], tap_shift};

   // The two top bits of the widened sum disagree exactly when the true
   // result falls outside the DATA_W range; the top bit gives the direction.
   always_comb begin
      result_o = sum[DATA_W-1:0];
      if (sum[DATA_W] != sum[DATA_W-1]) begin
         result_o = sum[DATA_W] ? MIN_V : MAX_V;
      end
   end
`else
   // Low DATA_W bits of the widened sum are identical to a DATA_W-bit add.
   assign result_o = dry_i + tap_shift;
`endif

endmodule : echo_mix

// File: rtl/echo_delay_scheduler.sv
// -----------------------------------------------------------------------------
// echo_delay_scheduler
// Sequences one echo per accepted audio sample over an external single-port
// synchronous RAM used as a circular delay line:
//   IDLE -> READ (address the tap) -> MIX (tap arrives, mix) -> WRITE
//   (store mix as feedback, present result) -> IDLE.
// Only one sample is in flight; strobes arriving while busy are dropped and
// flagged on the sticky overrun output.
// Build macro: ECHO_SATURATE_EN (clamp instead of wrap in echo_mix).
// Ports
//   clock          in   1        system clock, posedge
//   reset_n        in   1        asynchronous active-low reset
//   sample_valid   in   1        input_sample strobe
//   input_sample   in   DATA_W   signed dry sample
//   cfg_load       in   1        load cfg_delay/cfg_atten (honoured in IDLE)
//   cfg_delay      in   ADDR_W   delay length in samples, 0 treated as 1
//   cfg_atten      in   4        tap attenuation shift
//   ram_addr       out  ADDR_W   RAM address (always the delay pointer)
//   ram_we         out  1        RAM write enable, high only in WRITE
//   ram_wdata      out  DATA_W   RAM write data
//   ram_rdata      in   DATA_W   RAM read data, one cycle after address
//   output_sample  out  DATA_W   mixed sample, held until next result
//   output_valid   out  1        output_sample updated this cycle
//   overrun        out  1        sticky: strobe arrived while busy
// -----------------------------------------------------------------------------
module echo_delay_scheduler
   import echo_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     sample_valid,
   input  logic signed [DATA_W-1:0] input_sample,
   input  logic                     cfg_load,
   input  logic        [ADDR_W-1:0] cfg_delay,
   input  logic        [3:0]        cfg_atten,
   output logic        [ADDR_W-1:0] ram_addr,
   output logic                     ram_we,
   output logic signed [DATA_W-1:0] ram_wdata,
   input  logic signed [DATA_W-1:0] ram_rdata,
   output logic signed [DATA_W-1:0] output_sample,
   output logic                     output_valid,
   output logic                     overrun
);

   state_t                    state_q,     state_d;
   logic        [ADDR_W-1:0]  ptr_q,       ptr_d;
   logic        [ADDR_W-1:0]  len_q,       len_d;
   logic        [3:0]         atten_q,     atten_d;
   logic signed [DATA_W-1:0]  sample_q,    sample_d;
   logic signed [DATA_W-1:0]  out_q,       out_d;
   logic                      overrun_q,   overrun_d;
   logic                      wr_q,        wr_d;

   logic signed [DATA_W-1:0]  mix_result;

   // The tap arrives from the RAM during MIX; the result is registered at the
   // MIX->WRITE edge so it is stable while output_valid and ram_we are high.
   echo_mix #(
      .DATA_W (DATA_W)
   ) u_mix (
      .dry_i    (sample_q),
      .tap_i    (ram_rdata),
      .atten_i  (atten_q),
      .result_o (mix_result)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      len_d     = len_q;
      atten_d   = atten_q;
      sample_d  = sample_q;
      out_d     = out_q;
      overrun_d = overrun_q;

      case (state_q)
         IDLE: begin
            // A sample takes priority; a simultaneous cfg_load is dropped and
            // must be re-asserted by the requester.
            if (sample_valid) begin
               sample_d = input_sample;
               state_d  = READ;
            end else if (cfg_load) begin
               len_d     = (cfg_delay == '0) ? ADDR_W'(1) : cfg_delay;
               atten_d   = cfg_atten;
               ptr_d     = '0;
               overrun_d = 1'b0;
            end
         end
         READ: begin
            state_d = MIX;
         end
         MIX: begin
            out_d   = mix_result;
            state_d = WRITE;
         end
         WRITE: begin
            ptr_d   = (ptr_q == len_q - ADDR_W'(1)) ? '0 : ptr_q + ADDR_W'(1);
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if ((state_q != IDLE) && sample_valid) begin
         overrun_d = 1'b1;
      end

      // Write strobe is registered alongside the state so both RAM write
      // enable and output_valid come straight from flops.
      wr_d = (state_d == WRITE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         len_q     <= ADDR_W'(1);
         atten_q   <= ATTEN_RST;
         sample_q  <= '0;
         out_q     <= '0;
         overrun_q <= 1'b0;
         wr_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         len_q     <= len_d;
         atten_q   <= atten_d;
         sample_q  <= sample_d;
         out_q     <= out_d;
         overrun_q <= overrun_d;
         wr_q      <= wr_d;
      end
   end

   assign ram_addr      = ptr_q;
   assign ram_we        = wr_q;
   assign ram_wdata     = out_q;
   assign output_sample = out_q;
   assign output_valid  = wr_q;
   assign overrun       = overrun_q;

endmodule : echo_delay_scheduler
